// File: rtl/rr_sel_4way_16.sv
// rr_sel_4way_16: round-robin 4-way valid/ready arbiter with a registered output word and mux selects
module rr_sel_4way_16 #(
  parameter int         WIDTH     = 16,
  parameter logic [1:0] START_PTR = 2'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       in_valid,
  output logic [3:0]       in_ready,
  input  logic [WIDTH-1:0] in_data_0,
  input  logic [WIDTH-1:0] in_data_1,
  input  logic [WIDTH-1:0] in_data_2,
  input  logic [WIDTH-1:0] in_data_3,
  output logic             S1,
  output logic             S2,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d, sel_q, sel_d, win;
  logic             out_valid_q, out_valid_d, can_take, fire;
  logic [WIDTH-1:0] out_data_q, out_data_d, win_data;
  always_comb begin
    win = ptr_q;
    for (int i = 3; i >= 0; i--) win = in_valid[ptr_q + 2'(i)] ? ptr_q + 2'(i) : win;
    win_data = (win == 2'd0) ? in_data_0 :
               (win == 2'd1) ? in_data_1 :
               (win == 2'd2) ? in_data_2 : in_data_3;
    can_take = (state_q == IDLE) | out_ready;
    fire = can_take & |in_valid;
    in_ready = (fire & ~rst) ? (4'b0001 << win) : 4'b0000;
    state_d = fire ? HOLD : (out_ready ? IDLE : state_q);
    out_valid_d = (state_d == HOLD);
    ptr_d = fire ? win + 2'd1 : ptr_q;
    sel_d = fire ? win : sel_q;
    out_data_d = fire ? win_data : out_data_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= START_PTR;
      sel_q       <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end
  assign S1        = sel_q[0];
  assign S2        = sel_q[1];
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
endmodule

// File: tb/tb_rr_sel_4way_16.sv
// tb_rr_sel_4way_16: directed table-driven checks of the round-robin capture stage
module tb_rr_sel_4way_16;
  logic        clk = 1'b0, rst = 1'b1, out_ready = 1'b0;
  logic [3:0]  in_valid = 4'h0, in_ready;
  logic [15:0] in_data_0, in_data_1, in_data_2, in_data_3, out_data;
  logic        S1, S2, out_valid;
  int          n_run = 0, n_fail = 0;

  typedef struct {
    logic [3:0]  iv;
    logic        ordy;
    logic [15:0] d2;
    logic [3:0]  ir;
    logic        ov;
    logic [15:0] od;
    logic [1:0]  sel;
  } vec_t;
  vec_t vecs[24];

  rr_sel_4way_16 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data_0(in_data_0), .in_data_1(in_data_1), .in_data_2(in_data_2), .in_data_3(in_data_3),
    .S1(S1), .S2(S2), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int i);
    @(negedge clk);
    in_valid  = vecs[i].iv;
    out_ready = vecs[i].ordy;
    in_data_2 = vecs[i].d2;
    #1 chk($sformatf("v%0d in_ready", i), {12'h0, in_ready}, {12'h0, vecs[i].ir});
    @(posedge clk);
    #1;
    chk($sformatf("v%0d out_valid", i), {15'h0, out_valid}, {15'h0, vecs[i].ov});
    chk($sformatf("v%0d out_data", i), out_data, vecs[i].od);
    chk($sformatf("v%0d sel", i), {14'h0, S2, S1}, {14'h0, vecs[i].sel});
  endtask

  initial begin
    in_data_0 = 16'h1111; in_data_1 = 16'h2222; in_data_2 = 16'h3333; in_data_3 = 16'h4444;
    //          iv       rdy   d2         ir       ov    od         sel
    vecs[0]  = '{4'b0100, 1'b1, 16'hBEEF, 4'b0100, 1'b1, 16'hBEEF, 2'd2};
    vecs[1]  = '{4'b0000, 1'b1, 16'h3333, 4'b0000, 1'b0, 16'hBEEF, 2'd2};
    vecs[2]  = '{4'b1000, 1'b1, 16'h3333, 4'b1000, 1'b1, 16'h4444, 2'd3};
    vecs[3]  = '{4'b1111, 1'b1, 16'h3333, 4'b0001, 1'b1, 16'h1111, 2'd0};
    vecs[4]  = '{4'b1111, 1'b1, 16'h3333, 4'b0010, 1'b1, 16'h2222, 2'd1};
    vecs[5]  = '{4'b1111, 1'b1, 16'h3333, 4'b0100, 1'b1, 16'h3333, 2'd2};
    vecs[6]  = '{4'b1111, 1'b1, 16'h3333, 4'b1000, 1'b1, 16'h4444, 2'd3};
    vecs[7]  = '{4'b1111, 1'b1, 16'h3333, 4'b0001, 1'b1, 16'h1111, 2'd0};
    vecs[8]  = '{4'b1111, 1'b1, 16'h3333, 4'b0010, 1'b1, 16'h2222, 2'd1};
    vecs[9]  = '{4'b1111, 1'b0, 16'h3333, 4'b0000, 1'b1, 16'h2222, 2'd1};
    vecs[10] = '{4'b1111, 1'b0, 16'h3333, 4'b0000, 1'b1, 16'h2222, 2'd1};
    vecs[11] = '{4'b1111, 1'b0, 16'h3333, 4'b0000, 1'b1, 16'h2222, 2'd1};
    vecs[12] = '{4'b1111, 1'b0, 16'h3333, 4'b0000, 1'b1, 16'h2222, 2'd1};
    vecs[13] = '{4'b1111, 1'b0, 16'h3333, 4'b0000, 1'b1, 16'h2222, 2'd1};
    vecs[14] = '{4'b1111, 1'b1, 16'h3333, 4'b0100, 1'b1, 16'h3333, 2'd2};
    vecs[15] = '{4'b0010, 1'b1, 16'h3333, 4'b0010, 1'b1, 16'h2222, 2'd1};
    vecs[16] = '{4'b1111, 1'b1, 16'h3333, 4'b0100, 1'b1, 16'h3333, 2'd2};
    vecs[17] = '{4'b1111, 1'b0, 16'h3333, 4'b0000, 1'b1, 16'h3333, 2'd2};
    vecs[18] = '{4'b0000, 1'b1, 16'h3333, 4'b0000, 1'b0, 16'h3333, 2'd2};
    vecs[19] = '{4'b0000, 1'b1, 16'h3333, 4'b0000, 1'b0, 16'h3333, 2'd2};
    vecs[20] = '{4'b1111, 1'b1, 16'h3333, 4'b1000, 1'b1, 16'h4444, 2'd3};
    vecs[21] = '{4'b0000, 1'b1, 16'h3333, 4'b0000, 1'b0, 16'h4444, 2'd3};
    vecs[22] = '{4'b0010, 1'b0, 16'h3333, 4'b0010, 1'b1, 16'h2222, 2'd1};
    vecs[23] = '{4'b0000, 1'b0, 16'h3333, 4'b0000, 1'b1, 16'h2222, 2'd1};
    // reset with every channel requesting
    in_valid = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst in_ready", {12'h0, in_ready}, 16'h0);
    chk("rst out_valid", {15'h0, out_valid}, 16'h0);
    chk("rst out_data", out_data, 16'h0);
    chk("rst sel", {14'h0, S2, S1}, 16'h0);
    @(negedge clk);
    in_valid = 4'h0;
    rst = 1'b0;
    for (int i = 0; i < 24; i++) run_vec(i);
    // asynchronous reset while a word is held
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async out_valid", {15'h0, out_valid}, 16'h0);
    chk("async out_data", out_data, 16'h0);
    chk("async sel", {14'h0, S2, S1}, 16'h0);
    chk("async in_ready", {12'h0, in_ready}, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 4'hF;
    out_ready = 1'b1;
    #1 chk("post-rst ptr grant", {12'h0, in_ready}, 16'h0001);
    @(posedge clk);
    #1;
    chk("post-rst out_data", out_data, 16'h1111);
    chk("post-rst out_valid", {15'h0, out_valid}, 16'h1);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
